// File: rtl/tanh_sigm_pwl_pipe.sv
// tanh_sigm_pwl_pipe
//   Multi-lane piecewise-linear tanh / sigmoid approximation. The datapath uses only
//   shifts and adds. It has three register stages with valid/ready flow control, and
//   all lanes share one handshake and one mode bit.
//
//   Stage 1: optional sigmoid pre-scale (x>>>1), sign/magnitude split, segment select
//   Stage 2: per-segment shift-add magnitude
//   Stage 3: restore sign, optional sigmoid post-map ((t+One)>>>1)
//
// Ports
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_in_valid / o_in_ready    input handshake
//   i_in_mode                  0 = tanh, 1 = sigmoid, sampled with the beat
//   i_in_data                  NUM_CH signed lanes, lane i at [i*DATA_W +: DATA_W]
//   o_out_valid / i_out_ready  output handshake
//   o_out_data                 results, same lane packing
//   i_sat_clr, o_sat_cnt       saturation statistics, present only with TANH_SAT_STATS_EN
//
// Optional feature macro: TANH_SAT_STATS_EN
//   When defined, o_sat_cnt counts delivered beats in which any lane took the
//   saturating branch. The count sticks at 16'hFFFF, and i_sat_clr clears it.
//   An increment and a clear in the same cycle give 0.
module tanh_sigm_pwl_pipe #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FRAC_W = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic                       i_in_mode,
    input  logic [NUM_CH*DATA_W-1:0]   i_in_data,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [NUM_CH*DATA_W-1:0]   o_out_data
`ifdef TANH_SAT_STATS_EN
    ,
    input  logic                       i_sat_clr,
    output logic [15:0]                o_sat_cnt
`endif
);

    localparam logic [DATA_W-1:0] C_LSB      = DATA_W'(1);
    localparam logic [DATA_W-1:0] C_ONE      = C_LSB << FRAC_W;
    localparam logic [DATA_W-1:0] C_HALF     = C_ONE >> 1;
    localparam logic [DATA_W-1:0] C_QTR      = C_ONE >> 2;
    localparam logic [DATA_W-1:0] C_5_8      = (C_ONE >> 1) + (C_ONE >> 3);
    localparam logic [DATA_W-1:0] C_3_4      = (C_ONE >> 1) + (C_ONE >> 2);
    localparam logic [DATA_W-1:0] C_TWO      = C_ONE << 1;
    localparam logic [DATA_W-1:0] C_THREE    = C_ONE + (C_ONE << 1);
    localparam logic [DATA_W-1:0] C_MAX      = C_ONE - C_LSB;
    localparam logic [DATA_W-1:0] C_MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    localparam logic [2:0] SEG_LIN  = 3'd0;
    localparam logic [2:0] SEG_HALF = 3'd1;
    localparam logic [2:0] SEG_ONE  = 3'd2;
    localparam logic [2:0] SEG_TWO  = 3'd3;
    localparam logic [2:0] SEG_SAT  = 3'd4;

    // Pipeline advance: a stage loads when it is empty or when its successor moves on.
    logic w_en1, w_en2, w_en3;

    logic                           r_s1_vld, r_s1_mode;
    logic [NUM_CH-1:0]              r_s1_sign;
    logic [NUM_CH-1:0][DATA_W-1:0]  r_s1_mag;
    logic [NUM_CH-1:0][2:0]         r_s1_seg;

    logic                           r_s2_vld, r_s2_mode, r_s2_sat;
    logic [NUM_CH-1:0]              r_s2_sign;
    logic [NUM_CH-1:0][DATA_W-1:0]  r_s2_mag;

    logic                           r_s3_vld, r_s3_sat;
    logic [NUM_CH*DATA_W-1:0]       r_s3_data;

    logic [NUM_CH-1:0][DATA_W-1:0]  w_x;
    logic [NUM_CH-1:0]              w_s1_sign;
    logic [NUM_CH-1:0][DATA_W-1:0]  w_s1_mag;
    logic [NUM_CH-1:0][2:0]         w_s1_seg;
    logic [NUM_CH-1:0][DATA_W-1:0]  w_s2_mag;
    logic                           w_s2_sat;
    logic [NUM_CH-1:0][DATA_W-1:0]  w_t;
    logic [NUM_CH-1:0][DATA_W:0]    w_sum;
    logic [NUM_CH-1:0][DATA_W-1:0]  w_y;

    assign w_en3 = !r_s3_vld || i_out_ready;
    assign w_en2 = !r_s2_vld || w_en3;
    assign w_en1 = !r_s1_vld || w_en2;

    assign o_in_ready  = w_en1;
    assign o_out_valid = r_s3_vld;
    assign o_out_data  = r_s3_data;

    // Stage 1 combinational: pre-scale, sign/magnitude, segment select
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_x[i] = i_in_data[i*DATA_W +: DATA_W];
            if (i_in_mode) begin
                w_x[i] = {w_x[i][DATA_W-1], w_x[i][DATA_W-1:1]};
            end
            w_s1_sign[i] = w_x[i][DATA_W-1];
            w_s1_mag[i]  = w_s1_sign[i] ? (~w_x[i] + C_LSB) : w_x[i];
            // The most-negative value has no positive twin, so it goes straight to saturation.
            if (w_x[i] == C_MOST_NEG || w_s1_mag[i] >= C_THREE) begin
                w_s1_seg[i] = SEG_SAT;
            end else if (w_s1_mag[i] >= C_TWO) begin
                w_s1_seg[i] = SEG_TWO;
            end else if (w_s1_mag[i] >= C_ONE) begin
                w_s1_seg[i] = SEG_ONE;
            end else if (w_s1_mag[i] >= C_HALF) begin
                w_s1_seg[i] = SEG_HALF;
            end else begin
                w_s1_seg[i] = SEG_LIN;
            end
        end
    end

    // Stage 2 combinational: shift-add per segment; every result stays below One
    always_comb begin
        w_s2_sat = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (r_s1_seg[i])
                SEG_LIN:  w_s2_mag[i] = r_s1_mag[i];
                SEG_HALF: w_s2_mag[i] = (r_s1_mag[i] >> 1) + C_QTR;
                SEG_ONE:  w_s2_mag[i] = (r_s1_mag[i] >> 3) + C_5_8;
                SEG_TWO:  w_s2_mag[i] = (r_s1_mag[i] >> 4) + C_3_4;
                default:  w_s2_mag[i] = C_MAX;
            endcase
            if (r_s1_seg[i] == SEG_SAT) begin
                w_s2_sat = 1'b1;
            end
        end
    end

    // Stage 3 combinational: signed result, sigmoid maps [-One+1, One-1] onto [0, One-1]
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_t[i]   = r_s2_sign[i] ? (~r_s2_mag[i] + C_LSB) : r_s2_mag[i];
            w_sum[i] = {w_t[i][DATA_W-1], w_t[i]} + {1'b0, C_ONE};
            w_y[i]   = r_s2_mode ? w_sum[i][DATA_W:1] : w_t[i];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_mode <= 1'b0;
            r_s1_sign <= '0;
            r_s1_mag  <= '0;
            r_s1_seg  <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_mode <= 1'b0;
            r_s2_sat  <= 1'b0;
            r_s2_sign <= '0;
            r_s2_mag  <= '0;
            r_s3_vld  <= 1'b0;
            r_s3_sat  <= 1'b0;
            r_s3_data <= '0;
        end else begin
            if (w_en1) begin
                r_s1_vld <= i_in_valid;
            end
            if (w_en1 && i_in_valid) begin
                r_s1_mode <= i_in_mode;
                r_s1_sign <= w_s1_sign;
                r_s1_mag  <= w_s1_mag;
                r_s1_seg  <= w_s1_seg;
            end
            if (w_en2) begin
                r_s2_vld <= r_s1_vld;
            end
            if (w_en2 && r_s1_vld) begin
                r_s2_mode <= r_s1_mode;
                r_s2_sat  <= w_s2_sat;
                r_s2_sign <= r_s1_sign;
                r_s2_mag  <= w_s2_mag;
            end
            if (w_en3) begin
                r_s3_vld <= r_s2_vld;
            end
            // Only real beats overwrite the output, so o_out_data holds while stalled.
            if (w_en3 && r_s2_vld) begin
                r_s3_sat  <= r_s2_sat;
                r_s3_data <= w_y;
            end
        end
    end

`ifdef TANH_SAT_STATS_EN
    logic [15:0] r_sat_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sat_cnt <= '0;
        end else if (i_sat_clr) begin
            r_sat_cnt <= '0;
        end else if (r_s3_vld && i_out_ready && r_s3_sat && r_sat_cnt != 16'hFFFF) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign o_sat_cnt = r_sat_cnt;
`else
    logic w_unused_sat;
    assign w_unused_sat = r_s3_sat;
`endif

endmodule

// File: tb/tb_tanh_sigm_pwl_pipe.sv
// Self-checking bench for tanh_sigm_pwl_pipe (NUM_CH=4, DATA_W=8, FRAC_W=4).
// It uses directed vectors with hand-computed results. Streaming runs are checked
// against a small reference model, and TANH_SAT_STATS_EN enables the counter checks.
module tb_tanh_sigm_pwl_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef TANH_SAT_STATS_EN
    logic        sat_clr;
    logic [15:0] sat_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    tanh_sigm_pwl_pipe #(
        .NUM_CH (4),
        .DATA_W (8),
        .FRAC_W (4)
    ) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_mode   (in_mode),
        .i_in_data   (in_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data)
`ifdef TANH_SAT_STATS_EN
        ,
        .i_sat_clr   (sat_clr),
        .o_sat_cnt   (sat_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack4(input int l0, input int l1, input int l2, input int l3);
        return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
    endfunction

    // Reference model of one lane, written from the segment table.
    function automatic int model_lane(input int x_in, input bit mode);
        int x, a, m, t;
        bit s, sat;
        x = x_in;
        if (mode) x = x >>> 1;
        sat = (x == -128);
        s   = (x < 0);
        a   = s ? -x : x;
        if (sat || a >= 48)  m = 15;
        else if (a >= 32)    m = (a >> 4) + 12;
        else if (a >= 16)    m = (a >> 3) + 10;
        else if (a >= 8)     m = (a >> 1) + 4;
        else                 m = a;
        t = s ? -m : m;
        return mode ? ((t + 16) >>> 1) : t;
    endfunction

    function automatic logic [31:0] model_beat(input logic [31:0] d, input bit mode);
        logic [31:0] r;
        int          v;
        for (int i = 0; i < 4; i++) begin
            v = model_lane(int'($signed(d[i*8 +: 8])), mode);
            r[i*8 +: 8] = v[7:0];
        end
        return r;
    endfunction

    // One beat into an empty pipeline. Valid must rise exactly three edges after accept.
    task automatic send_check(input string tag, input logic [31:0] d, input bit mode,
                              input logic [31:0] exp);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = mode;
        #1 check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        check({tag, " lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        check({tag, " lat2"}, 32'(out_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        check({tag, " lat3 valid"}, 32'(out_valid), 32'd1);
        check({tag, " data"}, out_data, exp);
        @(posedge clk); @(negedge clk);
        check({tag, " drained"}, 32'(out_valid), 32'd0);
    endtask

    // Streams n beats at full input rate. out_ready is low on cycles stall_lo..stall_hi,
    // and alt toggles the mode on every beat.
    task automatic run_stream(input string tag, input int n, input int stall_lo,
                              input int stall_hi, input bit alt);
        logic [31:0] exp_q[$];
        logic [31:0] cur, prev_data;
        bit          prev_stall, saw_low, acc, dlv;
        int          sent, rcvd, cyc;
        sent = 0; rcvd = 0; cyc = 0;
        prev_stall = 1'b0; saw_low = 1'b0; prev_data = '0;
        cur = $urandom;
        while (rcvd < n && cyc < 400) begin
            out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
            in_valid  = (sent < n);
            in_data   = cur;
            in_mode   = alt ? sent[0] : 1'b0;
            #1;
            if (prev_stall) begin
                check({tag, " hold valid"}, 32'(out_valid), 32'd1);
                check({tag, " hold data"}, out_data, prev_data);
            end
            if (!in_ready) saw_low = 1'b1;
            if (stall_lo <= stall_hi && cyc == stall_hi)
                check({tag, " full in_ready"}, 32'(in_ready), 32'd0);
            acc = in_valid && in_ready;
            dlv = out_valid && out_ready;
            if (dlv) begin
                if (exp_q.size() == 0) check({tag, " extra beat"}, out_data, 32'hxxxx_xxxx);
                else check({tag, " beat"}, out_data, exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(model_beat(in_data, in_mode));
                sent++;
                cur = $urandom;
            end
            if (dlv) rcvd++;
            cyc++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, " received"}, 32'(rcvd), 32'(n));
        if (stall_lo <= stall_hi) check({tag, " saw backpressure"}, 32'(saw_low), 32'd1);
        else check({tag, " cycles"}, 32'(cyc), 32'(n + 3));
        #1 check({tag, " idle"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] a_beat;
        bit          saw_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef TANH_SAT_STATS_EN
        sat_clr   = 1'b0;
`endif
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", out_data, 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
`ifdef TANH_SAT_STATS_EN
        check("reset sat_cnt", 32'(sat_cnt), 32'd0);
`endif
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send_check("tanh segs", pack4(4, 12, 24, -40), 1'b0, pack4(4, 10, 13, -14));
`ifdef TANH_SAT_STATS_EN
        check("sat_cnt none", 32'(sat_cnt), 32'd0);
`endif
        send_check("tanh sat", pack4(48, 127, -128, 0), 1'b0, pack4(15, 15, -15, 0));
`ifdef TANH_SAT_STATS_EN
        check("sat_cnt one", 32'(sat_cnt), 32'd1);
        sat_clr = 1'b1;
        @(posedge clk); @(negedge clk);
        sat_clr = 1'b0;
        check("sat_cnt clr", 32'(sat_cnt), 32'd0);
`endif
        send_check("sigm", pack4(0, -128, 127, 16), 1'b1, pack4(8, 0, 15, 12));
        send_check("tanh small neg", pack4(-7, -8, -16, -32), 1'b0, pack4(-7, -8, -12, -14));

        run_stream("stall", 20, 5, 9, 1'b0);
        run_stream("altmode", 16, 1, 0, 1'b1);

        // Flush: two beats in flight and the output stalled, then an asynchronous reset.
        out_ready = 1'b0;
        a_beat    = pack4(4, 12, 24, -40);
        in_valid  = 1'b1;
        in_mode   = 1'b0;
        in_data   = a_beat;
        @(posedge clk); @(negedge clk);
        in_data   = pack4(1, 2, 3, 5);
        @(posedge clk); @(negedge clk);
        in_valid  = 1'b0;
        @(posedge clk); @(negedge clk);
        check("flush pre valid", 32'(out_valid), 32'd1);
        check("flush pre data", out_data, pack4(4, 10, 13, -14));
        #2 rst_n = 1'b0;
        #1;
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush out_data", out_data, 32'd0);
        check("flush in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("flush no stale", 32'(saw_valid), 32'd0);
        check("flush in_ready after", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
